// File: rtl/pi_current_loop_mc.sv
// Time-multiplexed multi-channel PI current regulator.
// One shared err/mul/acc datapath, per-channel integrator and anti-windup.
module pi_current_loop_mc #(
  parameter int NCH   = 2,
  parameter int IW    = 12,
  parameter int KW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 9,
  parameter int ACCW  = IW + KW
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCal_en,
  input  logic              iInt_clr,
  input  logic [NCH*IW-1:0] iTarget,
  input  logic [NCH*IW-1:0] iCurrent,
  input  logic [NCH*KW-1:0] iKp,
  input  logic [NCH*KW-1:0] iKi,
  input  logic [OW-2:0]     iU_max,
  output logic [NCH*OW-1:0] oCal,
  output logic              oCal_done,
  output logic              oBusy
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [IW:0] EMAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0] EMIN = -EMAX;
  localparam logic signed [ACCW:0] AMAX = {2'b00, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW:0] AMIN = -AMAX;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL, S_ACC, S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          k_q, k_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NCH*OW-1:0]      cal_q, cal_d;
  logic [NCH*IW-1:0]      tgt_q, tgt_d, cur_q, cur_d;
  logic [NCH*KW-1:0]      kp_q, kp_d, ki_q, ki_d;
  logic [OW-2:0]          umax_q, umax_d;
  logic signed [IW-1:0]   err_q, err_d;
  logic signed [ACCW-1:0] p_q, p_d, i_q, i_d;
  logic                   inh_q, inh_d;
  logic signed [ACCW:0]   sum_q, sum_d;
  logic signed [ACCW-1:0] integ_q [NCH];
  logic signed [ACCW-1:0] integ_d [NCH];
  logic [NCH-1:0]         sat_q, sat_d, neg_q, neg_d;

  logic signed [IW-1:0]   tgt_k, cur_k;
  logic signed [KW-1:0]   kp_k, ki_k;
  logic signed [IW:0]     e_w;
  logic signed [ACCW:0]   a_w, s_w, u_w, nu_w;
  logic signed [ACCW-1:0] integ_n;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    en_d    = iCal_en;
    done_d  = 1'b0;
    cal_d   = cal_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    umax_d  = umax_q;
    err_d   = err_q;
    p_d     = p_q;
    i_d     = i_q;
    inh_d   = inh_q;
    sum_d   = sum_q;
    integ_d = integ_q;
    sat_d   = sat_q;
    neg_d   = neg_q;
    tgt_k   = tgt_q[k_q*IW +: IW];
    cur_k   = cur_q[k_q*IW +: IW];
    kp_k    = kp_q[k_q*KW +: KW];
    ki_k    = ki_q[k_q*KW +: KW];
    e_w     = '0;
    a_w     = '0;
    integ_n = '0;
    s_w     = sum_q >>> SHIFT;
    u_w     = (ACCW+1)'({1'b0, umax_q});
    nu_w    = -u_w;
    unique case (state_q)
      S_IDLE: begin
        // clear lands before a coincident start's first ACC
        if (iInt_clr) begin
          integ_d = '{default: '0};
          sat_d   = '0;
        end
        if (iCal_en && !en_q) begin
          tgt_d   = iTarget;
          cur_d   = iCurrent;
          kp_d    = iKp;
          ki_d    = iKi;
          umax_d  = iU_max;
          k_d     = '0;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e_w = (IW+1)'(tgt_k) - (IW+1)'(cur_k);
        if (e_w > EMAX)      err_d = EMAX[IW-1:0];
        else if (e_w < EMIN) err_d = EMIN[IW-1:0];
        else                 err_d = e_w[IW-1:0];
        state_d = S_MUL;
      end
      S_MUL: begin
        p_d     = ACCW'(kp_k) * ACCW'(err_q);
        i_d     = ACCW'(ki_k) * ACCW'(err_q);
        inh_d   = sat_q[k_q] && (err_q[IW-1] == neg_q[k_q]);
        state_d = S_ACC;
      end
      S_ACC: begin
        a_w = (ACCW+1)'(integ_q[k_q])
            + (inh_q ? '0 : (ACCW+1)'(i_q));
        if (a_w > AMAX)      integ_n = AMAX[ACCW-1:0];
        else if (a_w < AMIN) integ_n = AMIN[ACCW-1:0];
        else                 integ_n = a_w[ACCW-1:0];
        integ_d[k_q] = integ_n;
        sum_d   = (ACCW+1)'(p_q) + (ACCW+1)'(integ_n);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (s_w >= u_w) begin
          cal_d[k_q*OW +: OW] = u_w[OW-1:0];
          sat_d[k_q] = 1'b1;
        end else if (s_w <= nu_w) begin
          cal_d[k_q*OW +: OW] = nu_w[OW-1:0];
          sat_d[k_q] = 1'b1;
        end else begin
          cal_d[k_q*OW +: OW] = s_w[OW-1:0];
          sat_d[k_q] = 1'b0;
        end
        neg_d[k_q] = sum_q[ACCW];
        if (k_q == CW'(NCH-1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cal_q   <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      umax_q  <= '0;
      err_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      inh_q   <= 1'b0;
      sum_q   <= '0;
      integ_q <= '{default: '0};
      sat_q   <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cal_q   <= cal_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      umax_q  <= umax_d;
      err_q   <= err_d;
      p_q     <= p_d;
      i_q     <= i_d;
      inh_q   <= inh_d;
      sum_q   <= sum_d;
      integ_q <= integ_d;
      sat_q   <= sat_d;
      neg_q   <= neg_d;
    end
  end

  assign oCal      = cal_q;
  assign oCal_done = done_q;
  assign oBusy     = busy_q;
endmodule

// File: tb/tb_pi_current_loop_mc.sv
// Bench for pi_current_loop_mc: directed scenarios plus random
// starts checked against an arithmetic per-channel PI model.
module tb_pi_current_loop_mc;
  localparam int NCH   = 2;
  localparam int IW    = 12;
  localparam int KW    = 16;
  localparam int OW    = 16;
  localparam int SHIFT = 9;
  localparam int ACCW  = IW + KW;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iCal_en;
  logic              iInt_clr;
  logic [NCH*IW-1:0] iTarget;
  logic [NCH*IW-1:0] iCurrent;
  logic [NCH*KW-1:0] iKp;
  logic [NCH*KW-1:0] iKi;
  logic [OW-2:0]     iU_max;
  logic [NCH*OW-1:0] oCal;
  logic              oCal_done;
  logic              oBusy;

  pi_current_loop_mc #(
    .NCH(NCH), .IW(IW), .KW(KW), .OW(OW),
    .SHIFT(SHIFT), .ACCW(ACCW)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iCal_en(iCal_en), .iInt_clr(iInt_clr),
    .iTarget(iTarget), .iCurrent(iCurrent),
    .iKp(iKp), .iKi(iKi), .iU_max(iU_max),
    .oCal(oCal), .oCal_done(oCal_done), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int     n_chk = 0;
  int     n_fail = 0;
  int     tgt [NCH];
  int     cur [NCH];
  int     kp [NCH];
  int     ki [NCH];
  int     umax;
  longint m_integ [NCH];
  longint m_out [NCH];
  bit     m_sat [NCH];
  bit     m_neg [NCH];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic longint ch_out(input int k);
    logic signed [OW-1:0] v;
    v = oCal[k*OW +: OW];
    return longint'(v);
  endfunction

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      iTarget[k*IW +: IW]  = IW'(tgt[k]);
      iCurrent[k*IW +: IW] = IW'(cur[k]);
      iKp[k*KW +: KW]      = KW'(kp[k]);
      iKi[k*KW +: KW]      = KW'(ki[k]);
    end
    iU_max = (OW-1)'(umax);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_integ[k] = 0;
      m_sat[k]   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_out[k] = 0;
      m_neg[k] = 1'b0;
    end
  endfunction

  // One full computation over all channels, straight from the PI rules.
  function automatic void model_run();
    longint err, p, ii, sum, s, lim, amax, u;
    lim  = (longint'(1) << (IW-1)) - 1;
    amax = (longint'(1) << (ACCW-1)) - 1;
    u    = umax;
    for (int k = 0; k < NCH; k++) begin
      err = tgt[k] - cur[k];
      if (err > lim) err = lim;
      if (err < -lim) err = -lim;
      p  = longint'(kp[k]) * err;
      ii = longint'(ki[k]) * err;
      if (!(m_sat[k] && ((err < 0) == m_neg[k])))
        m_integ[k] += ii;
      if (m_integ[k] > amax) m_integ[k] = amax;
      if (m_integ[k] < -amax) m_integ[k] = -amax;
      sum = p + m_integ[k];
      s   = sum >>> SHIFT;
      if (s >= u) begin
        m_out[k] = u;  m_sat[k] = 1'b1;
      end else if (s <= -u) begin
        m_out[k] = -u; m_sat[k] = 1'b1;
      end else begin
        m_out[k] = s;  m_sat[k] = 1'b0;
      end
      m_neg[k] = (sum < 0);
    end
  endfunction

  task automatic start(input bit clr);
    drive();
    iInt_clr = clr;
    iCal_en  = 1'b1;
    if (clr) model_clear();
    tick();
    check("busy_t0", oBusy, 0);
    iCal_en  = 1'b0;
    iInt_clr = 1'b0;
    iTarget  = (NCH*IW)'($urandom);
    iCurrent = (NCH*IW)'($urandom);
    iKp      = $urandom;
    iKi      = $urandom;
    iU_max   = (OW-1)'($urandom);
    model_run();
    for (int c = 1; c <= 4*NCH; c++) begin
      tick();
      check("done", oCal_done, c == 4*NCH);
      check("busy", oBusy, c != 4*NCH);
      if (c % 4 == 0)
        check($sformatf("cal_ch%0d", c/4-1), ch_out(c/4-1),
              m_out[c/4-1]);
    end
    tick();
    check("done_low", oCal_done, 0);
  endtask

  task automatic set_ponly();
    tgt[0] = 100; cur[0] = 0; kp[0] = 512; ki[0] = 0;
    tgt[1] = -50; cur[1] = 0; kp[1] = 512; ki[1] = 0;
    umax = 30000;
  endtask

  initial begin
    int dones;
    int d8;
    int d17;
    int r;
    iRst = 1'b1; iCal_en = 1'b0; iInt_clr = 1'b0;
    iTarget = '0; iCurrent = '0; iKp = '0; iKi = '0; iU_max = '0;
    model_reset();
    tick(); tick();
    check("rst_cal", oCal, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oCal_done, 0);
    iRst = 1'b0;
    tick();

    set_ponly();
    start(1'b0);
    check("ponly_ch0", ch_out(0), 100);
    check("ponly_ch1", ch_out(1), -50);

    kp[0] = 0; ki[0] = 512; tgt[0] = 10; cur[0] = 0;
    for (int n = 1; n <= 3; n++) begin
      start(1'b0);
      check($sformatf("integ_%0d", n), ch_out(0), 10*n);
    end
    iInt_clr = 1'b1;
    tick();
    iInt_clr = 1'b0;
    model_clear();
    start(1'b0);
    check("integ_clr", ch_out(0), 10);

    tgt[0] = 2047; cur[0] = -2047; kp[0] = 16384; ki[0] = 512;
    start(1'b0);
    check("sat_hi", ch_out(0), 30000);
    start(1'b0);
    check("sat_hold", ch_out(0), 30000);
    tgt[0] = -2047; cur[0] = 2047; kp[0] = 0;
    start(1'b0);
    check("sat_leave", ch_out(0) < 30000, 1);

    umax = 1000; ki[0] = 0; kp[0] = 16384; kp[1] = 16384;
    tgt[0] = 2047; cur[0] = -2047;
    tgt[1] = -2047; cur[1] = 2047;
    start(1'b0);
    check("lim_pos", ch_out(0), 1000);
    check("lim_neg", ch_out(1), -1000);

    set_ponly();
    umax = 0;
    start(1'b0);
    check("umax0_ch0", ch_out(0), 0);
    check("umax0_ch1", ch_out(1), 0);

    set_ponly();
    drive();
    iCal_en = 1'b1;
    dones = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (oCal_done) dones++;
    end
    iCal_en = 1'b0;
    tick();
    model_run();
    check("hold_high_dones", dones, 1);
    check("hold_ch0", ch_out(0), m_out[0]);

    iCal_en = 1'b1;
    tick();
    dones = 0; d8 = 0; d17 = 0;
    for (int c = 1; c <= 20; c++) begin
      iCal_en = (c >= 3 && c <= 7) || (c >= 9 && c <= 10);
      tick();
      if (oCal_done) begin
        dones++;
        if (c == 8) d8 = 1;
        if (c == 17) d17 = 1;
      end
    end
    iCal_en = 1'b0;
    tick();
    model_run();
    model_run();
    check("hs_dones", dones, 2);
    check("hs_done_t8", d8, 1);
    check("hs_done_t17", d17, 1);
    check("hs_ch1", ch_out(1), m_out[1]);

    drive();
    iCal_en = 1'b1;
    tick();
    iCal_en = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    iRst = 1'b1;
    #2;
    check("midrst_cal", oCal, 0);
    check("midrst_busy", oBusy, 0);
    tick();
    iRst = 1'b0;
    model_reset();
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (oCal_done) dones++;
    end
    check("midrst_nodone", dones, 0);
    start(1'b0);
    check("midrst_ch0", ch_out(0), 100);
    check("midrst_ch1", ch_out(1), -50);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NCH; k++) begin
        tgt[k] = int'($urandom_range(4095)) - 2048;
        cur[k] = int'($urandom_range(4095)) - 2048;
        kp[k]  = int'($urandom_range(65535)) - 32768;
        ki[k]  = int'($urandom_range(8191)) - 4096;
      end
      umax = ($urandom_range(7) == 0) ? 0
           : int'($urandom_range(32767));
      r = int'($urandom_range(4));
      if (r == 0) begin
        iInt_clr = 1'b1;
        tick();
        iInt_clr = 1'b0;
        model_clear();
      end
      start(r == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
